// File: rtl/stream_pkg.sv
// Shared transform-mode constants and width helper for the stream_proc streaming stage.
package stream_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BSWAP  = 2'd1;
  localparam logic [1:0] MODE_ACCUM  = 2'd2;
  localparam logic [1:0] MODE_INVERT = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/stream_buf.sv
// Circular elastic buffer with push/pop ports; the caller guarantees no push when full
// and no pop when empty.
module stream_buf
  import stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [clog2(DEPTH):0] level
);

  localparam int PTR_W   = clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/stream_proc.sv
// FIFO-to-FIFO streaming stage: transforms each word on ingress, buffers it elastically
// and forwards it at up to one word per cycle, with debug level and throughput counters.
module stream_proc
  import stream_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int BUF_DEPTH       = 4,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  mode,
  input  logic                        clear,
  output logic                        fifo_in_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0]  fifo_in_dout,
  input  logic                        fifo_in_empty,
  output logic                        fifo_out_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0]  fifo_out_din,
  input  logic                        fifo_out_full,
  output logic [clog2(BUF_DEPTH):0]   buf_level,
  output logic [COUNT_WIDTH-1:0]      words_in,
  output logic [COUNT_WIDTH-1:0]      words_out
);

  localparam int LEVEL_W   = clog2(BUF_DEPTH) + 1;
  localparam int NUM_BYTES = FIFO_DATA_WIDTH / 8;

  logic [FIFO_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [FIFO_DATA_WIDTH-1:0] acc_sum;
  logic [FIFO_DATA_WIDTH-1:0] stored_word;
  logic [COUNT_WIDTH-1:0]     words_in_q, words_in_d;
  logic [COUNT_WIDTH-1:0]     words_out_q, words_out_d;
  logic [LEVEL_W-1:0]         level;
  logic                       rd_en;
  logic                       wr_en;

  // Both handshakes look only at the registered level, so fifo_out_full never reaches rd_en.
  assign rd_en = !reset && !fifo_in_empty && (level < LEVEL_W'(BUF_DEPTH));
  assign wr_en = !reset && !fifo_out_full && (level != '0);

  assign fifo_in_rd_en  = rd_en;
  assign fifo_out_wr_en = wr_en;
  assign buf_level      = level;
  assign words_in       = words_in_q;
  assign words_out      = words_out_q;

  // A clear in the same cycle as an ACCUM read restarts the sum from this word.
  always_comb begin
    acc_sum     = (clear ? '0 : acc_q) + fifo_in_dout;
    stored_word = fifo_in_dout;
    case (mode)
      MODE_BSWAP: begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          stored_word[8*i +: 8] = fifo_in_dout[8*(NUM_BYTES-1-i) +: 8];
        end
      end
      MODE_ACCUM:  stored_word = acc_sum;
      MODE_INVERT: stored_word = ~fifo_in_dout;
      default:     stored_word = fifo_in_dout;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    words_in_d  = words_in_q + COUNT_WIDTH'(rd_en);
    words_out_d = words_out_q + COUNT_WIDTH'(wr_en);
    if (clear) begin
      acc_d       = '0;
      words_in_d  = '0;
      words_out_d = '0;
    end
    if (rd_en && (mode == MODE_ACCUM)) begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      words_in_q  <= '0;
      words_out_q <= '0;
    end else begin
      acc_q       <= acc_d;
      words_in_q  <= words_in_d;
      words_out_q <= words_out_d;
    end
  end

  stream_buf #(
    .WIDTH (FIFO_DATA_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_en),
    .push_data (stored_word),
    .pop       (wr_en),
    .head_data (fifo_out_din),
    .level     (level)
  );

endmodule

// File: tb/tb_stream_proc.sv
// Directed bench for stream_proc: table of single-word transform vectors plus
// hand-written streaming, backpressure, reset and starvation sequences.
module tb_stream_proc;

  logic        clock;
  logic        reset;
  logic [1:0]  mode;
  logic        clear;
  logic        fifo_in_rd_en;
  logic [31:0] fifo_in_dout;
  logic        fifo_in_empty;
  logic        fifo_out_wr_en;
  logic [31:0] fifo_out_din;
  logic        fifo_out_full;
  logic [2:0]  buf_level;
  logic [31:0] words_in;
  logic [31:0] words_out;

  stream_proc #(
    .FIFO_DATA_WIDTH (32),
    .BUF_DEPTH       (4),
    .COUNT_WIDTH     (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .clear          (clear),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .buf_level      (buf_level),
    .words_in       (words_in),
    .words_out      (words_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  mode;
    logic        clr;
    logic [31:0] din;
    logic [31:0] expected;
  } vec_t;

  vec_t        vectors [14];
  logic [31:0] in_q [$];
  logic [31:0] exp_q [$];
  int          checks;
  int          failures;
  bit          last_rd;
  bit          last_wr;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // One word through an otherwise empty stage: read cycle, then write cycle.
  task automatic applyStimulus(input vec_t v);
    mode          = v.mode;
    clear         = v.clr;
    fifo_in_dout  = v.din;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    #1;
    checkOutput("tbl_rd_en", 32'(fifo_in_rd_en), 32'd1);
    @(posedge clock); #1;
    clear         = 1'b0;
    fifo_in_empty = 1'b1;
    #1;
    checkOutput("tbl_wr_en", 32'(fifo_out_wr_en), 32'd1);
    checkOutput("tbl_data", fifo_out_din, v.expected);
    @(posedge clock); #1;
  endtask

  // Models the input FIFO from in_q and scores written words against exp_q.
  task automatic runCycle(input bit starve);
    logic        rd;
    logic        wr;
    logic [31:0] din;
    logic [31:0] want;
    fifo_in_empty = starve || (in_q.size() == 0);
    fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 32'h0;
    #1;
    rd  = fifo_in_rd_en;
    wr  = fifo_out_wr_en;
    din = fifo_out_din;
    checkOutput("rd_while_empty", 32'(rd && fifo_in_empty), 32'd0);
    checkOutput("wr_unexpected", 32'(wr && (exp_q.size() == 0)), 32'd0);
    if (wr && (exp_q.size() != 0)) begin
      want = exp_q.pop_front();
      checkOutput("stream_data", din, want);
    end
    @(posedge clock); #1;
    if (rd && (in_q.size() != 0)) void'(in_q.pop_front());
    last_rd = rd;
    last_wr = wr;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_rd, first_wr, last_rd_cycle, rd_count;
    bit starve, pending;

    checks   = 0;
    failures = 0;
    // acc = 11 after the wrap, held through PASS, restarted by the clear vector.
    vectors[0]  = '{2'd0, 1'b0, 32'h12345678, 32'h12345678};
    vectors[1]  = '{2'd1, 1'b0, 32'h11223344, 32'h44332211};
    vectors[2]  = '{2'd3, 1'b0, 32'h0000FFFF, 32'hFFFF0000};
    vectors[3]  = '{2'd2, 1'b0, 32'h00000005, 32'h00000005};
    vectors[4]  = '{2'd2, 1'b0, 32'h00000007, 32'h0000000C};
    vectors[5]  = '{2'd2, 1'b0, 32'hFFFFFFFF, 32'h0000000B};
    vectors[6]  = '{2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vectors[7]  = '{2'd2, 1'b0, 32'h00000001, 32'h0000000C};
    vectors[8]  = '{2'd2, 1'b1, 32'h00000003, 32'h00000003};
    vectors[9]  = '{2'd2, 1'b0, 32'h00000004, 32'h00000007};
    vectors[10] = '{2'd3, 1'b0, 32'hFFFFFFFF, 32'h00000000};
    vectors[11] = '{2'd1, 1'b0, 32'h000000AB, 32'hAB000000};
    vectors[12] = '{2'd0, 1'b1, 32'h00000010, 32'h00000010};
    vectors[13] = '{2'd2, 1'b0, 32'h00000002, 32'h00000002};

    reset         = 1'b1;
    mode          = 2'd0;
    clear         = 1'b0;
    fifo_in_dout  = 32'h99;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    checkOutput("reset_rd_en", 32'(fifo_in_rd_en), 32'd0);
    checkOutput("reset_wr_en", 32'(fifo_out_wr_en), 32'd0);
    reset         = 1'b0;
    fifo_in_empty = 1'b1;
    #1;
    checkOutput("reset_level", 32'(buf_level), 32'd0);
    checkOutput("reset_words_in", words_in, 32'd0);
    checkOutput("reset_words_out", words_out, 32'd0);
    checkOutput("reset_din", fifo_out_din, 32'd0);
    checkOutput("reset_idle_wr", 32'(fifo_out_wr_en), 32'd0);
    @(posedge clock); #1;

    for (int i = 0; i < 14; i++) applyStimulus(vectors[i]);
    // Last clear coincided with a read: only the final ACCUM read and two writes count.
    checkOutput("tbl_words_in", words_in, 32'd1);
    checkOutput("tbl_words_out", words_out, 32'd2);

    mode  = 2'd0;
    clear = 1'b1;
    runCycle(1'b0);
    clear = 1'b0;
    checkOutput("clear_words_in", words_in, 32'd0);

    for (int i = 1; i <= 8; i++) begin
      in_q.push_back(32'(i));
      exp_q.push_back(32'(i));
    end
    first_rd = -1; first_wr = -1; last_rd_cycle = -1; rd_count = 0;
    for (int c = 0; c < 12; c++) begin
      runCycle(1'b0);
      if (last_rd) begin
        if (first_rd < 0) first_rd = c;
        rd_count++;
        last_rd_cycle = c;
      end
      if (last_wr && (first_wr < 0)) first_wr = c;
    end
    checkOutput("stream_rd_count", 32'(rd_count), 32'd8);
    checkOutput("stream_rd_span", 32'(last_rd_cycle - first_rd), 32'd7);
    checkOutput("stream_first_wr", 32'(first_wr - first_rd), 32'd1);
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("stream_words_in", words_in, 32'd8);
    checkOutput("stream_words_out", words_out, 32'd8);

    fifo_out_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_q.push_back(32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
    end
    rd_count = 0;
    for (int c = 0; c < 10; c++) begin
      runCycle(1'b0);
      if (last_rd) rd_count++;
    end
    checkOutput("bp_rd_count", 32'(rd_count), 32'd4);
    checkOutput("bp_level_full", 32'(buf_level), 32'd4);
    checkOutput("bp_waiting", 32'(in_q.size()), 32'd2);
    fifo_out_full = 1'b0;
    for (int c = 0; c < 12; c++) runCycle(1'b0);
    checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("bp_in_empty", 32'(in_q.size()), 32'd0);
    checkOutput("bp_level_empty", 32'(buf_level), 32'd0);

    for (int i = 0; i < 6; i++) begin
      in_q.push_back(32'h200 + 32'(i));
      exp_q.push_back(32'h200 + 32'(i));
    end
    for (int c = 0; c < 16; c++) begin
      starve  = (c % 2) == 1;
      pending = (in_q.size() != 0) && !starve;
      runCycle(starve);
      if (pending) checkOutput("starve_rd_en", 32'(last_rd), 32'd1);
      checkOutput("starve_level_max", 32'(buf_level <= 3'd1), 32'd1);
    end
    checkOutput("starve_drained", 32'(exp_q.size()), 32'd0);

    fifo_out_full = 1'b1;
    in_q.push_back(32'h301);
    in_q.push_back(32'h302);
    in_q.push_back(32'h303);
    for (int c = 0; c < 3; c++) runCycle(1'b0);
    checkOutput("rst_pre_level", 32'(buf_level), 32'd3);
    in_q.delete();
    fifo_in_dout  = 32'h77;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    reset         = 1'b1;
    #1;
    checkOutput("rst_mid_rd_en", 32'(fifo_in_rd_en), 32'd0);
    checkOutput("rst_mid_wr_en", 32'(fifo_out_wr_en), 32'd0);
    @(posedge clock); #1;
    checkOutput("rst_hold_rd_en", 32'(fifo_in_rd_en), 32'd0);
    checkOutput("rst_hold_wr_en", 32'(fifo_out_wr_en), 32'd0);
    reset         = 1'b0;
    fifo_in_empty = 1'b1;
    #1;
    checkOutput("rst_post_level", 32'(buf_level), 32'd0);
    checkOutput("rst_post_words_in", words_in, 32'd0);
    checkOutput("rst_post_words_out", words_out, 32'd0);
    checkOutput("rst_post_wr_en", 32'(fifo_out_wr_en), 32'd0);
    checkOutput("rst_post_din", fifo_out_din, 32'd0);
    @(posedge clock); #1;
    exp_q.delete();
    in_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'hA5A5A5A5);
    for (int c = 0; c < 4; c++) runCycle(1'b0);
    checkOutput("rst_restart_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("rst_restart_words_in", words_in, 32'd1);
    checkOutput("rst_restart_words_out", words_out, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
